// File: rtl/axi_regfile_v2.sv
// AXI4-Lite slave register file with read-only and self-clearing register masks,
// SLVERR on illegal accesses, and per-register write/read strobes. The AW and W
// channels are captured independently, so either may arrive first or both together.
// Every AXI output is driven from a flop.
module axi_regfile_v2 #(
  parameter int                  C_S_AXI_DATA_WIDTH = 32,
  parameter int                  NREG               = 16,
  parameter int                  C_S_AXI_ADDR_WIDTH = $clog2(NREG) + 2,
  parameter logic [NREG-1:0]     RO_MASK            = '0,
  parameter logic [NREG-1:0]     SC_MASK            = '0,
  parameter logic [NREG*32-1:0]  RESET_VAL          = '0
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [NREG*32-1:0]              slv_reg,
  input  logic [NREG*32-1:0]              slv_read,
  output logic [NREG-1:0]                 slv_wr_pulse,
  output logic [NREG-1:0]                 slv_rd_pulse
);

  localparam int IW = C_S_AXI_ADDR_WIDTH - 2;

  logic          aw_held, w_held;
  logic [IW-1:0] aw_idx, ar_idx;
  logic [31:0]   w_data;
  logic [3:0]    w_strb;
  logic          aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
  logic          aw_held_n, w_held_n, bvalid_n, rvalid_n;
  logic          wr_legal, ar_legal;
  logic [NREG-1:0] wr_sel, rd_sel;
  logic [31:0]   rd_word;

  // Address bits below the word and the protection attributes carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], S_AXI_AWPROT, S_AXI_ARPROT};

  assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

  // Handshakes and next-state of the per-channel held/valid flags.
  always_comb begin
    aw_hs     = S_AXI_AWVALID && S_AXI_AWREADY;
    w_hs      = S_AXI_WVALID && S_AXI_WREADY;
    b_hs      = S_AXI_BVALID && S_AXI_BREADY;
    ar_hs     = S_AXI_ARVALID && S_AXI_ARREADY;
    r_hs      = S_AXI_RVALID && S_AXI_RREADY;
    commit    = aw_held && w_held && !S_AXI_BVALID;
    aw_held_n = (aw_held || aw_hs) && !b_hs;
    w_held_n  = (w_held || w_hs) && !b_hs;
    bvalid_n  = commit || (S_AXI_BVALID && !b_hs);
    rvalid_n  = ar_hs || (S_AXI_RVALID && !r_hs);
  end

  // Address decode: an index with no matching register selects nothing and is illegal.
  always_comb begin
    wr_sel   = '0;
    rd_sel   = '0;
    wr_legal = 1'b0;
    ar_legal = 1'b0;
    rd_word  = '0;
    for (int i = 0; i < NREG; i++) begin
      if (aw_idx == IW'(i) && !RO_MASK[i]) begin
        wr_sel[i] = 1'b1;
        wr_legal  = 1'b1;
      end
      if (ar_idx == IW'(i)) begin
        rd_sel[i] = 1'b1;
        ar_legal  = 1'b1;
        rd_word   = slv_read[32*i +: 32];
      end
    end
  end

  // Write address/data capture, ready generation and write response.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_idx        <= '0;
      w_data        <= '0;
      w_strb        <= '0;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= 2'b00;
    end else begin
      aw_held       <= aw_held_n;
      w_held        <= w_held_n;
      if (aw_hs) aw_idx <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
      if (w_hs) begin
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      S_AXI_AWREADY <= !aw_held_n && !bvalid_n;
      S_AXI_WREADY  <= !w_held_n && !bvalid_n;
      S_AXI_BVALID  <= bvalid_n;
      if (commit) S_AXI_BRESP <= wr_legal ? 2'b00 : 2'b10;
    end
  end

  // Register array: self-clearing entries fall back to their reset value every cycle
  // unless written on that edge; strobed byte lanes override the fallback.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      slv_reg      <= RESET_VAL;
      slv_wr_pulse <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        slv_wr_pulse[i] <= 1'b0;
        if (SC_MASK[i]) slv_reg[32*i +: 32] <= RESET_VAL[32*i +: 32];
        if (commit && wr_sel[i]) begin
          slv_wr_pulse[i] <= 1'b1;
          for (int b = 0; b < 4; b++) begin
            if (w_strb[b]) slv_reg[32*i + 8*b +: 8] <= w_data[8*b +: 8];
          end
        end
      end
    end
  end

  // Read channel: data is sampled on the AR handshake and held until RREADY.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= 2'b00;
      slv_rd_pulse  <= '0;
    end else begin
      S_AXI_ARREADY <= !rvalid_n;
      S_AXI_RVALID  <= rvalid_n;
      slv_rd_pulse  <= '0;
      if (ar_hs) begin
        S_AXI_RDATA  <= rd_word;
        S_AXI_RRESP  <= ar_legal ? 2'b00 : 2'b10;
        slv_rd_pulse <= rd_sel;
      end
    end
  end

endmodule

// File: tb/tb_axi_regfile_v2.sv
// Scoreboard bench for axi_regfile_v2: expected responses are queued when a
// transaction is issued and popped when the DUT answers.
module tb_axi_regfile_v2;

  localparam int NREG = 16;
  localparam int AW   = 7;
  localparam logic [NREG-1:0]    RO = 16'h0002;
  localparam logic [NREG-1:0]    SC = 16'h0008;
  localparam logic [NREG*32-1:0] RV = (512'h1111_1111 << 32) | (512'h0000_0030 << 96)
                                    | (512'hDEAD_BEEF << 160);
  localparam logic [31:0]        STATUS = 32'h5A5A_0F0F;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [AW-1:0] S_AXI_AWADDR = '0, S_AXI_ARADDR = '0;
  logic [2:0]    S_AXI_AWPROT = '0, S_AXI_ARPROT = '0;
  logic          S_AXI_AWVALID = 0, S_AXI_WVALID = 0, S_AXI_BREADY = 0;
  logic          S_AXI_ARVALID = 0, S_AXI_RREADY = 0;
  logic [31:0]   S_AXI_WDATA = '0;
  logic [3:0]    S_AXI_WSTRB = '0;
  logic          S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID;
  logic [1:0]    S_AXI_BRESP, S_AXI_RRESP;
  logic [31:0]   S_AXI_RDATA;
  logic [NREG*32-1:0] slv_reg, slv_read;
  logic [NREG-1:0]    slv_wr_pulse, slv_rd_pulse;

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt[NREG];
  int rd_cnt[NREG];
  int sc_hits = 0;

  logic [31:0] model[NREG];
  logic [1:0]  b_q[$];
  logic [33:0] r_q[$];
  logic [NREG-1:0]    ro_v = RO;
  logic [NREG-1:0]    sc_v = SC;
  logic [NREG*32-1:0] rv_v = RV;

  axi_regfile_v2 #(
    .C_S_AXI_DATA_WIDTH(32), .NREG(NREG), .C_S_AXI_ADDR_WIDTH(AW),
    .RO_MASK(RO), .SC_MASK(SC), .RESET_VAL(RV)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .slv_reg(slv_reg), .slv_read(slv_read),
    .slv_wr_pulse(slv_wr_pulse), .slv_rd_pulse(slv_rd_pulse)
  );

  always #5 clk = ~clk;

  // Fabric loops registers back except the top one, which reports a fixed status word.
  always_comb begin
    slv_read = slv_reg;
    slv_read[15*32 +: 32] = STATUS;
  end

  // Count strobe cycles and cycles in which the self-clearing register shows 1.
  always @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (slv_wr_pulse[i]) wr_cnt[i]++;
      if (slv_rd_pulse[i]) rd_cnt[i]++;
    end
    if (slv_reg[3*32 +: 32] == 32'h1) sc_hits++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  function automatic logic [31:0] reg_word(input int i);
    return slv_reg[32*i +: 32];
  endfunction

  function automatic int sum_cnt(input bit rd);
    int s = 0;
    for (int i = 0; i < NREG; i++) s += rd ? rd_cnt[i] : wr_cnt[i];
    return s;
  endfunction

  task automatic reset_model();
    for (int i = 0; i < NREG; i++) model[i] = rv_v[32*i +: 32];
    b_q.delete();
    r_q.delete();
  endtask

  task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] r);
    r = 2'b10;
    if (idx < NREG) begin
      if (!ro_v[idx]) begin
        r = 2'b00;
        if (!sc_v[idx])
          for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
      end
    end
  endtask

  task automatic model_read(input int idx, output logic [33:0] e);
    if (idx >= NREG)     e = {2'b10, 32'h0};
    else if (idx == 15)  e = {2'b00, STATUS};
    else                 e = {2'b00, model[idx]};
  endtask

  task automatic do_reset();
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
    S_AXI_BREADY = 0;  S_AXI_RREADY = 0;
    rst = 1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 0;
    @(posedge clk); #1;
    reset_model();
  endtask

  task automatic send_aw(input logic [AW-1:0] a, input int dly, output bit ok);
    bit rdy;
    ok = 0;
    repeat (dly) begin @(posedge clk); #1; end
    S_AXI_AWADDR = a; S_AXI_AWVALID = 1;
    for (int i = 0; i < 100; i++) begin
      rdy = S_AXI_AWREADY;
      @(posedge clk); #1;
      if (rdy) begin ok = 1; break; end
    end
    S_AXI_AWVALID = 0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly, output bit ok);
    bit rdy;
    ok = 0;
    repeat (dly) begin @(posedge clk); #1; end
    S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1;
    for (int i = 0; i < 100; i++) begin
      rdy = S_AXI_WREADY;
      @(posedge clk); #1;
      if (rdy) begin ok = 1; break; end
    end
    S_AXI_WVALID = 0;
  endtask

  task automatic send_ar(input logic [AW-1:0] a, input int dly, output bit ok);
    bit rdy;
    ok = 0;
    repeat (dly) begin @(posedge clk); #1; end
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1;
    for (int i = 0; i < 100; i++) begin
      rdy = S_AXI_ARREADY;
      @(posedge clk); #1;
      if (rdy) begin ok = 1; break; end
    end
    S_AXI_ARVALID = 0;
  endtask

  task automatic get_b(input int hold, output logic [1:0] resp, output bit ok);
    ok = 0; resp = 2'bxx;
    for (int i = 0; i < 100; i++) begin
      if (S_AXI_BVALID) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) return;
    resp = S_AXI_BRESP;
    repeat (hold) begin @(posedge clk); #1; end
    S_AXI_BREADY = 1;
    @(posedge clk); #1;
    S_AXI_BREADY = 0;
  endtask

  task automatic get_r(input int hold, output logic [33:0] got, output bit ok);
    ok = 0; got = 'x;
    for (int i = 0; i < 100; i++) begin
      if (S_AXI_RVALID) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) return;
    got = {S_AXI_RRESP, S_AXI_RDATA};
    repeat (hold) begin @(posedge clk); #1; end
    S_AXI_RREADY = 1;
    @(posedge clk); #1;
    S_AXI_RREADY = 0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int hold,
                          output logic [1:0] resp, output bit ok);
    bit ok_aw, ok_w, ok_b;
    fork
      send_aw(a, aw_dly, ok_aw);
      send_w(d, s, w_dly, ok_w);
    join
    get_b(hold, resp, ok_b);
    ok = ok_aw && ok_w && ok_b;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int hold,
                         output logic [33:0] got, output bit ok);
    bit ok_ar, ok_r;
    send_ar(a, 0, ok_ar);
    get_r(hold, got, ok_r);
    ok = ok_ar && ok_r;
  endtask

  task automatic test_reset();
    logic [1:0] resp, exp;
    bit ok, bv_seen;
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID,
         S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got nonzero expected all zero");
    end
    n_cmp++;
    if (slv_reg !== RV || slv_wr_pulse !== '0 || slv_rd_pulse !== '0) begin
      n_err++; $display("FAIL reset_regs: got %0h expected %0h", slv_reg, RV);
    end
    rst = 0;
    reset_model();
    n_cmp++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b000) begin
      n_err++; $display("FAIL ready_at_release: got %b expected 000",
                        {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
      n_err++; $display("FAIL ready_after_release: got %b expected 111",
                        {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
    end
    model_write(0, 32'h1234_5678, 4'hF, exp); b_q.push_back(exp);
    do_write(7'h00, 32'h1234_5678, 4'hF, 0, 0, 0, resp, ok);
    exp = b_q.pop_front();
    n_cmp++;
    if (!ok || resp !== exp) begin
      n_err++; $display("FAIL pre_reset_write: got %b ok=%0d expected %b", resp, ok, exp);
    end
    n_cmp++;
    if (reg_word(0) !== 32'h1234_5678) begin
      n_err++; $display("FAIL pre_reset_reg0: got %h expected 12345678", reg_word(0));
    end
    send_aw(7'h00, 0, ok);
    @(posedge clk); #1;
    rst = 1;
    #1;
    n_cmp++;
    if (reg_word(0) !== 32'h0 || S_AXI_AWREADY !== 1'b0 || S_AXI_BVALID !== 1'b0) begin
      n_err++; $display("FAIL mid_write_reset: got reg0=%h awready=%b bvalid=%b expected 0/0/0",
                        reg_word(0), S_AXI_AWREADY, S_AXI_BVALID);
    end
    @(posedge clk); #1;
    rst = 0;
    reset_model();
    send_w(32'hFFFF_FFFF, 4'hF, 1, ok);
    bv_seen = 0;
    repeat (10) begin bv_seen |= S_AXI_BVALID; @(posedge clk); #1; end
    n_cmp++;
    if (bv_seen !== 1'b0 || reg_word(0) !== 32'h0) begin
      n_err++; $display("FAIL dropped_write: got bvalid_seen=%b reg0=%h expected 0/0",
                        bv_seen, reg_word(0));
    end
    do_reset();
  endtask

  task automatic test_w_before_aw();
    logic [1:0] resp, exp;
    bit ok;
    int c0 = wr_cnt[2];
    model_write(2, 32'hA5A5_A5A5, 4'b0101, exp); b_q.push_back(exp);
    do_write(7'h08, 32'hA5A5_A5A5, 4'b0101, 3, 0, 0, resp, ok);
    exp = b_q.pop_front();
    n_cmp++;
    if (!ok || resp !== exp) begin
      n_err++; $display("FAIL w_first_bresp: got %b ok=%0d expected %b", resp, ok, exp);
    end
    n_cmp++;
    if (reg_word(2) !== 32'h00A5_00A5) begin
      n_err++; $display("FAIL w_first_reg2: got %h expected 00a500a5", reg_word(2));
    end
    n_cmp++;
    if (wr_cnt[2] - c0 !== 1) begin
      n_err++; $display("FAIL w_first_pulse: got %0d cycles expected 1", wr_cnt[2] - c0);
    end
  endtask

  task automatic test_read_only();
    logic [1:0] resp, exp;
    logic [33:0] got, rexp;
    bit ok;
    int w0 = wr_cnt[1];
    int r0 = rd_cnt[1];
    model_write(1, 32'hFFFF_FFFF, 4'hF, exp); b_q.push_back(exp);
    do_write(7'h04, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, resp, ok);
    exp = b_q.pop_front();
    n_cmp++;
    if (!ok || resp !== exp) begin
      n_err++; $display("FAIL ro_bresp: got %b ok=%0d expected %b", resp, ok, exp);
    end
    n_cmp++;
    if (reg_word(1) !== 32'h1111_1111 || wr_cnt[1] !== w0) begin
      n_err++; $display("FAIL ro_unchanged: got %h pulses=%0d expected 11111111 pulses=0",
                        reg_word(1), wr_cnt[1] - w0);
    end
    model_read(1, rexp); r_q.push_back(rexp);
    do_read(7'h04, 0, got, ok);
    rexp = r_q.pop_front();
    n_cmp++;
    if (!ok || got !== rexp) begin
      n_err++; $display("FAIL ro_read: got %h ok=%0d expected %h", got, ok, rexp);
    end
    n_cmp++;
    if (rd_cnt[1] - r0 !== 1) begin
      n_err++; $display("FAIL ro_rd_pulse: got %0d expected 1", rd_cnt[1] - r0);
    end
  endtask

  task automatic test_illegal();
    logic [1:0] resp, exp;
    logic [33:0] got, rexp;
    bit ok;
    int rs = sum_cnt(1);
    int ws = sum_cnt(0);
    int w4;
    model_read(16, rexp); r_q.push_back(rexp);
    do_read(7'h40, 0, got, ok);
    rexp = r_q.pop_front();
    n_cmp++;
    if (!ok || got !== rexp || sum_cnt(1) !== rs) begin
      n_err++; $display("FAIL oob_read: got %h ok=%0d expected %h", got, ok, rexp);
    end
    model_write(17, 32'hCAFE_F00D, 4'hF, exp); b_q.push_back(exp);
    do_write(7'h44, 32'hCAFE_F00D, 4'hF, 0, 0, 0, resp, ok);
    exp = b_q.pop_front();
    n_cmp++;
    if (!ok || resp !== exp || sum_cnt(0) !== ws) begin
      n_err++; $display("FAIL oob_write: got %b ok=%0d expected %b", resp, ok, exp);
    end
    w4 = wr_cnt[4];
    model_write(4, 32'hFFFF_FFFF, 4'h0, exp); b_q.push_back(exp);
    do_write(7'h10, 32'hFFFF_FFFF, 4'h0, 0, 0, 0, resp, ok);
    exp = b_q.pop_front();
    n_cmp++;
    if (!ok || resp !== exp || reg_word(4) !== 32'h0 || wr_cnt[4] - w4 !== 1) begin
      n_err++; $display("FAIL zero_strb: got resp=%b reg4=%h pulses=%0d expected %b/0/1",
                        resp, reg_word(4), wr_cnt[4] - w4, exp);
    end
  endtask

  task automatic test_self_clear();
    logic [1:0] resp, exp;
    bit ok;
    int h0 = sc_hits;
    model_write(3, 32'h1, 4'hF, exp); b_q.push_back(exp);
    do_write(7'h0C, 32'h1, 4'hF, 0, 0, 0, resp, ok);
    repeat (2) begin @(posedge clk); #1; end
    exp = b_q.pop_front();
    n_cmp++;
    if (!ok || resp !== exp) begin
      n_err++; $display("FAIL sc_bresp: got %b expected %b", resp, exp);
    end
    n_cmp++;
    if (sc_hits - h0 !== 1 || reg_word(3) !== 32'h30) begin
      n_err++; $display("FAIL sc_one_cycle: got %0d cycles reg3=%h expected 1 cycle reg3=30",
                        sc_hits - h0, reg_word(3));
    end
    h0 = sc_hits;
    for (int k = 0; k < 2; k++) begin
      model_write(3, 32'h1, 4'hF, exp); b_q.push_back(exp);
      do_write(7'h0C, 32'h1, 4'hF, 0, 0, 0, resp, ok);
      exp = b_q.pop_front();
    end
    repeat (2) begin @(posedge clk); #1; end
    n_cmp++;
    if (sc_hits - h0 !== 2 || reg_word(3) !== 32'h30) begin
      n_err++; $display("FAIL sc_rearm: got %0d cycles reg3=%h expected 2 cycles reg3=30",
                        sc_hits - h0, reg_word(3));
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] resp, exp;
    logic [33:0] got, rexp;
    bit ok_aw, ok_w, ok;
    model_write(17, 32'h0, 4'hF, exp); b_q.push_back(exp);
    fork
      send_aw(7'h44, 0, ok_aw);
      send_w(32'h0, 4'hF, 0, ok_w);
    join
    for (int i = 0; i < 20 && !S_AXI_BVALID; i++) begin @(posedge clk); #1; end
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== 2'b10 ||
          S_AXI_AWREADY !== 1'b0 || S_AXI_WREADY !== 1'b0) begin
        n_err++; $display("FAIL b_hold cycle %0d: got bv=%b resp=%b awr=%b wr=%b expected 1/10/0/0",
                          i, S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY, S_AXI_WREADY);
      end
      @(posedge clk); #1;
    end
    get_b(0, resp, ok);
    exp = b_q.pop_front();
    n_cmp++;
    if (!ok || resp !== exp) begin
      n_err++; $display("FAIL b_hold_resp: got %b expected %b", resp, exp);
    end
    model_read(15, rexp); r_q.push_back(rexp);
    send_ar(7'h3C, 0, ok);
    for (int i = 0; i < 20 && !S_AXI_RVALID; i++) begin @(posedge clk); #1; end
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (S_AXI_RVALID !== 1'b1 || {S_AXI_RRESP, S_AXI_RDATA} !== rexp || S_AXI_ARREADY !== 1'b0) begin
        n_err++; $display("FAIL r_hold cycle %0d: got rv=%b r=%h arr=%b expected 1/%h/0",
                          i, S_AXI_RVALID, {S_AXI_RRESP, S_AXI_RDATA}, S_AXI_ARREADY, rexp);
      end
      @(posedge clk); #1;
    end
    get_r(0, got, ok);
    rexp = r_q.pop_front();
    n_cmp++;
    if (!ok || got !== rexp || S_AXI_ARREADY !== 1'b1 || S_AXI_RVALID !== 1'b0) begin
      n_err++; $display("FAIL r_release: got %h arr=%b rv=%b expected %h/1/0",
                        got, S_AXI_ARREADY, S_AXI_RVALID, rexp);
    end
  endtask

  task automatic test_rw_same();
    logic [1:0] resp, exp;
    logic [33:0] got, rexp;
    bit ok, ok_ar, ok_r;
    model_write(6, 32'h1111_2222, 4'hF, exp); b_q.push_back(exp);
    do_write(7'h18, 32'h1111_2222, 4'hF, 0, 0, 0, resp, ok);
    exp = b_q.pop_front();
    model_read(6, rexp); r_q.push_back(rexp);
    model_write(6, 32'h3333_4444, 4'hF, exp); b_q.push_back(exp);
    fork
      do_write(7'h18, 32'h3333_4444, 4'hF, 0, 0, 0, resp, ok);
      begin
        send_ar(7'h18, 1, ok_ar);
        get_r(0, got, ok_r);
      end
    join
    exp = b_q.pop_front();
    rexp = r_q.pop_front();
    n_cmp++;
    if (!ok || !ok_ar || !ok_r || got !== rexp || resp !== exp) begin
      n_err++; $display("FAIL rw_same_old: got %h/%b expected %h/%b", got, resp, rexp, exp);
    end
    model_read(6, rexp); r_q.push_back(rexp);
    do_read(7'h18, 0, got, ok);
    rexp = r_q.pop_front();
    n_cmp++;
    if (!ok || got !== rexp) begin
      n_err++; $display("FAIL rw_same_new: got %h expected %h", got, rexp);
    end
  endtask

  task automatic test_soak();
    logic [1:0] resp, exp;
    logic [33:0] got, rexp;
    logic [31:0] d;
    logic [3:0] s;
    bit ok;
    int idx;
    for (int n = 0; n < 1000; n++) begin
      idx = $urandom_range(17, 0);
      if ($urandom_range(1, 0) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(15, 0));
        model_write(idx, d, s, exp); b_q.push_back(exp);
        do_write(7'(idx * 4), d, s, $urandom_range(3, 0), $urandom_range(3, 0),
                 $urandom_range(3, 0), resp, ok);
        exp = b_q.pop_front();
        n_cmp++;
        if (!ok || resp !== exp) begin
          n_err++; $display("FAIL soak_write %0d idx %0d: got %b expected %b", n, idx, resp, exp);
        end
      end else begin
        model_read(idx, rexp); r_q.push_back(rexp);
        do_read(7'(idx * 4), $urandom_range(3, 0), got, ok);
        rexp = r_q.pop_front();
        n_cmp++;
        if (!ok || got !== rexp) begin
          n_err++; $display("FAIL soak_read %0d idx %0d: got %h expected %h", n, idx, got, rexp);
        end
      end
    end
    for (int i = 0; i < NREG; i++) begin
      n_cmp++;
      if (reg_word(i) !== model[i]) begin
        n_err++; $display("FAIL soak_final reg %0d: got %h expected %h", i, reg_word(i), model[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) begin wr_cnt[i] = 0; rd_cnt[i] = 0; end
    reset_model();
    test_reset();
    test_w_before_aw();
    test_read_only();
    test_illegal();
    test_self_clear();
    test_backpressure();
    test_rw_same();
    test_soak();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
